// File: rtl/dmem_hs.sv
// dmem_hs: data memory with valid/ready request and response channels.
// Synchronous read with RD_LATENCY cycles from accept to response valid;
// one transaction in flight; the response is held until accepted.
// Optional feature macro: DMEM_ERR_EN (misaligned / out-of-range requests
// are flagged on op_rsp_err, and erroneous writes commit nothing).
//
// state  | meaning
// S_IDLE | ready for a new request
// S_WAIT | read accepted, counting down wait states
// S_RESP | response valid, held until ip_rsp_ready

module dmem_hs #(
  parameter int          SIZE_IN_WORDS = 1024,
  parameter int          DATA_WIDTH    = 32,
  parameter int          RD_LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR     = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ip_req_valid,
  output logic                      op_req_ready,
  input  logic                      ip_req_wr,
  input  logic [31:0]               ip_req_addr,
  input  logic [DATA_WIDTH/8-1:0]   ip_req_mask,
  input  logic [DATA_WIDTH-1:0]     ip_req_wdata,
  output logic                      op_rsp_valid,
  input  logic                      ip_rsp_ready,
  output logic [DATA_WIDTH-1:0]     op_rsp_rdata,
  output logic                      op_rsp_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(NB);
  localparam int IDX_W = $clog2(SIZE_IN_WORDS);
  localparam bit LAT1  = (RD_LATENCY == 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [SIZE_IN_WORDS];

  logic [2:0]       cnt;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_err;

  logic [31:0]      off_addr;
  logic [IDX_W-1:0] req_idx;
  logic             req_err;
  logic             accept;
  logic             wr_commit;
  logic             capture;
  logic [IDX_W-1:0] cap_idx;
  logic             cap_err;
  logic             unused_off;

  assign off_addr   = ip_req_addr - BASE_ADDR;
  assign req_idx    = off_addr[IDX_W+OFF-1:OFF];
  // Not every offset bit feeds the index; the reduction keeps them referenced.
  assign unused_off = ^off_addr;

`ifdef DMEM_ERR_EN
  localparam logic [32:0] MEM_BYTES = 33'(SIZE_IN_WORDS) * 33'(NB);
  // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
  assign req_err = (ip_req_addr[OFF-1:0] != '0) || ({1'b0, off_addr} >= MEM_BYTES);
`else
  assign req_err = 1'b0;
`endif

  assign op_req_ready = (state == S_IDLE) & rst_n;
  assign accept       = ip_req_valid & op_req_ready;
  assign wr_commit    = accept & ip_req_wr & ~req_err;

  // Next-state, response-valid and read-capture decode.
  always_comb begin
    state_nxt    = state;
    op_rsp_valid = 1'b0;
    capture      = 1'b0;
    cap_idx      = rd_idx;
    cap_err      = rd_err;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (ip_req_wr) begin
            state_nxt = S_RESP;
          end else if (LAT1) begin
            state_nxt = S_RESP;
            capture   = 1'b1;
            cap_idx   = req_idx;
            cap_err   = req_err;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 3'd1) begin
          state_nxt = S_RESP;
          capture   = 1'b1;
        end
      end
      S_RESP: begin
        op_rsp_valid = 1'b1;
        if (ip_rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Wait-state down-counter and latched read request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 3'd0;
      rd_idx <= '0;
      rd_err <= 1'b0;
    end else if (accept) begin
      cnt    <= ip_req_wr ? 3'd0 : 3'(RD_LATENCY - 1);
      rd_idx <= req_idx;
      rd_err <= req_err;
    end else if (state == S_WAIT) begin
      cnt <= cnt - 3'd1;
    end
  end

  // Response data/error; held while in S_RESP since nothing else loads them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_rsp_rdata <= '0;
      op_rsp_err   <= 1'b0;
    end else if (accept && ip_req_wr) begin
      op_rsp_rdata <= '0;
      op_rsp_err   <= req_err;
    end else if (capture) begin
      op_rsp_rdata <= cap_err ? '0 : mem[cap_idx];
      op_rsp_err   <= cap_err;
    end
  end

  // Byte-masked write commit at the accept edge; array contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int b = 0; b < NB; b++) begin
        if (ip_req_mask[b]) mem[req_idx][8*b +: 8] <= ip_req_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_hs.sv
// Testbench for dmem_hs (32-bit words, 1024 deep, RD_LATENCY=4, base 0).
// A transaction-level model predicts ready/valid/rdata/err every cycle;
// directed transactions pin the model with literal expectations.

module tb_dmem_hs;

  localparam int LAT   = 4;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ip_req_valid = 1'b0;
  logic        op_req_ready;
  logic        ip_req_wr = 1'b0;
  logic [31:0] ip_req_addr = 32'h0;
  logic [3:0]  ip_req_mask = 4'h0;
  logic [31:0] ip_req_wdata = 32'h0;
  logic        op_rsp_valid;
  logic        ip_rsp_ready = 1'b0;
  logic [31:0] op_rsp_rdata;
  logic        op_rsp_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_hs #(
    .SIZE_IN_WORDS(DEPTH),
    .DATA_WIDTH(32),
    .RD_LATENCY(LAT),
    .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ip_req_valid(ip_req_valid),
    .op_req_ready(op_req_ready),
    .ip_req_wr(ip_req_wr),
    .ip_req_addr(ip_req_addr),
    .ip_req_mask(ip_req_mask),
    .ip_req_wdata(ip_req_wdata),
    .op_rsp_valid(op_rsp_valid),
    .ip_rsp_ready(ip_rsp_ready),
    .op_rsp_rdata(op_rsp_rdata),
    .op_rsp_err(op_rsp_err)
  );

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] ref_mem [DEPTH];
  bit          m_pending = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_rdata = 32'h0;
  bit          m_err = 1'b0;
  int          m_idx;
  bit          m_e;

  function automatic bit addr_err(input logic [31:0] a);
`ifdef DMEM_ERR_EN
    return (a % 4 != 0) || (a >= 32'd4096);
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  // One transaction at a time: accepted when idle, response after the
  // access latency, retired on the handshake; reset drops anything pending.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending = 1'b0;
      m_wait    = 0;
    end else if (m_pending) begin
      if (m_wait == 0) begin
        if (ip_rsp_ready) m_pending = 1'b0;
      end else begin
        m_wait = m_wait - 1;
      end
    end else if (ip_req_valid) begin
      m_idx     = int'((ip_req_addr / 4) % DEPTH);
      m_e       = addr_err(ip_req_addr);
      m_pending = 1'b1;
      m_err     = m_e;
      if (ip_req_wr) begin
        m_wait  = 0;
        m_rdata = 32'h0;
        if (!m_e)
          for (int b = 0; b < 4; b++)
            if (ip_req_mask[b]) ref_mem[m_idx][8*b +: 8] = ip_req_wdata[8*b +: 8];
      end else begin
        m_wait  = LAT - 1;
        m_rdata = m_e ? 32'h0 : ref_mem[m_idx];
      end
    end
  end

  bit chk_en = 1'b0;

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("req_ready", 32'(op_req_ready), 32'(rst_n && !m_pending));
      cmp("rsp_valid", 32'(op_rsp_valid), 32'(m_pending && m_wait == 0));
      if (!rst_n) begin
        cmp("rst_rdata", op_rsp_rdata, 32'h0);
        cmp("rst_err", 32'(op_rsp_err), 32'h0);
      end else if (m_pending && m_wait == 0) begin
        cmp("rsp_rdata", op_rsp_rdata, m_rdata);
        cmp("rsp_err", 32'(op_rsp_err), 32'(m_err));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] rd, rdl;
  logic        er;
  int          lat;

  task automatic xact(input bit wr, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] wd, input int stall, input bit push,
                      output logic [31:0] rdata, output logic [31:0] rdata_last,
                      output logic err, output int latency);
    int n;
    rdata = 32'h0; rdata_last = 32'h0; err = 1'b0; latency = -1;
    @(negedge clk);
    ip_req_valid = 1'b1; ip_req_wr = wr; ip_req_addr = addr;
    ip_req_mask = mask; ip_req_wdata = wd;
    n = 0;
    while (!op_req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      cmp("accept_timeout", 32'(n), 32'd0);
      ip_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ip_req_valid = 1'b0; ip_req_wr = 1'($urandom); ip_req_addr = $urandom;
    n = 0;
    forever begin
      @(negedge clk); n++;
      if (op_rsp_valid || n >= 50) break;
      ip_rsp_ready = 1'($urandom);
    end
    if (!op_rsp_valid) begin
      cmp("rsp_timeout", 32'(n), 32'd0);
      ip_rsp_ready = 1'b0;
      return;
    end
    latency = n;
    rdata = op_rsp_rdata; err = op_rsp_err;
    ip_rsp_ready = 1'b0;
    if (push) begin
      ip_req_valid = 1'b1; ip_req_wr = 1'b1; ip_req_mask = 4'hF;
      ip_req_addr = 32'h4 * $urandom_range(0, 15); ip_req_wdata = $urandom;
    end
    for (int i = 0; i < stall; i++) @(negedge clk);
    rdata_last = op_rsp_rdata;
    ip_rsp_ready = 1'b1; ip_req_valid = 1'b0;
    @(posedge clk); #1;
    ip_rsp_ready = 1'b0;
  endtask

  logic [31:0] a;

  initial begin
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    cmp("reset_ready", 32'(op_req_ready), 32'h0);
    cmp("reset_valid", 32'(op_rsp_valid), 32'h0);
    cmp("reset_rdata", op_rsp_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cmp("idle_ready", 32'(op_req_ready), 32'h1);

    xact(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 1'b0, rd, rdl, er, lat);
    cmp("wr_latency", 32'(lat), 32'd1);
    cmp("wr_rdata", rd, 32'h0);
    xact(1'b0, 32'h10, 4'h0, 32'h0, 0, 1'b0, rd, rdl, er, lat);
    cmp("rd_latency", 32'(lat), 32'd4);
    cmp("rd_rdata", rd, 32'hDEADBEEF);

    xact(1'b1, 32'h20, 4'hF, 32'h11223344, 1, 1'b0, rd, rdl, er, lat);
    xact(1'b1, 32'h20, 4'b0010, 32'h0000AA00, 0, 1'b0, rd, rdl, er, lat);
    xact(1'b0, 32'h20, 4'h0, 32'h0, 3, 1'b1, rd, rdl, er, lat);
    cmp("mask_rdata", rd, 32'h1122AA44);
    cmp("stall_latency", 32'(lat), 32'd4);
    cmp("stall_rdata_end", rdl, 32'h1122AA44);
    @(negedge clk);
    cmp("idle_after_hs", 32'(op_req_ready), 32'h1);

    xact(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 0, 1'b0, rd, rdl, er, lat);
    cmp("mask0_rsp_rdata", rd, 32'h0);
    xact(1'b0, 32'h20, 4'h0, 32'h0, 0, 1'b0, rd, rdl, er, lat);
    cmp("mask0_unchanged", rd, 32'h1122AA44);

    // Reset while a read is waiting: the read must vanish.
    @(negedge clk);
    ip_req_valid = 1'b1; ip_req_wr = 1'b0; ip_req_addr = 32'h10;
    @(posedge clk); #1 ip_req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b0;
    #1;
    cmp("wait_rst_valid", 32'(op_rsp_valid), 32'h0);
    cmp("wait_rst_ready", 32'(op_req_ready), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      cmp("no_rsp_after_rst", 32'(op_rsp_valid), 32'h0);
    end
    xact(1'b0, 32'h10, 4'h0, 32'h0, 0, 1'b0, rd, rdl, er, lat);
    cmp("post_rst_rdata", rd, 32'hDEADBEEF);
    cmp("post_rst_latency", 32'(lat), 32'd4);

    xact(1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 0, 1'b0, rd, rdl, er, lat);
    xact(1'b0, 32'h1000, 4'h0, 32'h0, 0, 1'b0, rd, rdl, er, lat);
`ifdef DMEM_ERR_EN
    cmp("oor_err", 32'(er), 32'h1);
    cmp("oor_rdata", rd, 32'h0);
`else
    cmp("wrap_err", 32'(er), 32'h0);
    cmp("wrap_rdata", rd, 32'hCAFEF00D);
`endif
    xact(1'b1, 32'h3, 4'hF, 32'h12345678, 0, 1'b0, rd, rdl, er, lat);
`ifdef DMEM_ERR_EN
    cmp("misalign_err", 32'(er), 32'h1);
`else
    cmp("misalign_err", 32'(er), 32'h0);
`endif
    xact(1'b0, 32'h0, 4'h0, 32'h0, 0, 1'b0, rd, rdl, er, lat);
`ifdef DMEM_ERR_EN
    cmp("misalign_nowrite", rd, 32'hCAFEF00D);
`else
    cmp("misalign_write", rd, 32'h12345678);
`endif

    // Known contents for the randomized window.
    for (int w = 0; w < 16; w++)
      xact(1'b1, 32'(w * 4), 4'hF, $urandom, 0, 1'b0, rd, rdl, er, lat);

    for (int t = 0; t < 300; t++) begin
      a = 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'(4096 * $urandom_range(1, 3));
      xact(1'($urandom), a, 4'($urandom), $urandom, $urandom_range(0, 3),
           1'($urandom), rd, rdl, er, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
